// File: rtl/rv_iopmp_err_queue.sv
// IOPMP error-record queue: per-instance hold registers, round-robin arbiter, DEPTH-entry FIFO.
// Optional drop counter enabled by defining RV_IOPMP_ERRQ_DROPCNT_EN.
module rv_iopmp_err_queue #(
  parameter int NUMBER_IOPMP_INSTANCES = 1,
  parameter int DEPTH                  = 4,
  parameter int ADDR_WIDTH             = 64,
  parameter int RRID_WIDTH             = 16,
  localparam int N  = NUMBER_IOPMP_INSTANCES,
  localparam int SW = (N > 1) ? $clog2(N) : 1,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            clear_i,
  input  logic [N-1:0]                    err_valid_i,
  input  logic [N-1:0][1:0]               err_ttype_i,
  input  logic [N-1:0][2:0]               err_etype_i,
  input  logic [N-1:0][RRID_WIDTH-1:0]    err_rrid_i,
  input  logic [N-1:0][ADDR_WIDTH-1:0]    err_addr_i,
  output logic                            err_valid_o,
  input  logic                            err_ready_i,
  output logic [1:0]                      err_ttype_o,
  output logic [2:0]                      err_etype_o,
  output logic [RRID_WIDTH-1:0]           err_rrid_o,
  output logic [ADDR_WIDTH-1:0]           err_addr_o,
  output logic [SW-1:0]                   err_src_o,
  output logic [LW-1:0]                   level_o,
  output logic                            lost_o,
  output logic [15:0]                     drop_cnt_o
);

  localparam int PW    = $clog2(DEPTH);
  localparam int REC_W = SW + 2 + 3 + RRID_WIDTH + ADDR_WIDTH;

  logic [N-1:0]                 hold_full;
  logic [N-1:0][1:0]            hold_ttype;
  logic [N-1:0][2:0]            hold_etype;
  logic [N-1:0][RRID_WIDTH-1:0] hold_rrid;
  logic [N-1:0][ADDR_WIDTH-1:0] hold_addr;

  logic [SW-1:0]    rr_ptr;
  logic [SW-1:0]    gnt_idx;
  logic             gnt_any;
  logic [N-1:0]     gnt_oh;
  logic [N-1:0]     load_vec;
  logic [N-1:0]     drop_vec;

  logic [REC_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    level;
  logic             lost;
  logic             fifo_full;
  logic             push;
  logic             pop;
  logic [REC_W-1:0] head;
  int               j;

  assign fifo_full = (level == LW'(DEPTH));

  // Round-robin search starting at rr_ptr; a full FIFO never grants, even when popping.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    gnt_oh  = '0;
    j       = 0;
    if (!fifo_full) begin
      for (int k = 0; k < N; k++) begin
        j = int'(rr_ptr) + k;
        if (j >= N) j = j - N;
        if (!gnt_any && hold_full[j]) begin
          gnt_any = 1'b1;
          gnt_idx = SW'(j);
        end
      end
    end
    if (gnt_any) gnt_oh[gnt_idx] = 1'b1;
  end

  // A hold accepts a pulse when empty or when it is being drained into the FIFO this cycle.
  assign load_vec = clear_i ? '0 : (err_valid_i & (~hold_full | gnt_oh));
  assign drop_vec = clear_i ? '0 : (err_valid_i & hold_full & ~gnt_oh);

  assign push = gnt_any;
  // Handshake: a head record transfers on a cycle where err_valid_o && err_ready_i;
  // while err_valid_o is high and err_ready_i low the head fields hold still.
  assign pop  = (level != '0) && err_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      hold_full <= '0;
      rr_ptr    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      lost      <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (load_vec[i])    hold_full[i] <= 1'b1;
        else if (gnt_oh[i]) hold_full[i] <= 1'b0;
      end
      if (gnt_any) rr_ptr <= (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + SW'(1);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (!push && pop) level <= level - LW'(1);
      if (|drop_vec) lost <= 1'b1;
    end
  end

  // Record payloads carry no reset; validity is tracked by hold_full and level.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < N; i++) begin
      if (load_vec[i]) begin
        hold_ttype[i] <= err_ttype_i[i];
        hold_etype[i] <= err_etype_i[i];
        hold_rrid[i]  <= err_rrid_i[i];
        hold_addr[i]  <= err_addr_i[i];
      end
    end
    if (push) mem[wr_ptr] <= {gnt_idx, hold_ttype[gnt_idx], hold_etype[gnt_idx],
                              hold_rrid[gnt_idx], hold_addr[gnt_idx]};
  end

  assign head = (level != '0) ? mem[rd_ptr] : '0;
  assign {err_src_o, err_ttype_o, err_etype_o, err_rrid_o, err_addr_o} = head;
  assign err_valid_o = (level != '0);
  assign level_o     = level;
  assign lost_o      = lost;

`ifdef RV_IOPMP_ERRQ_DROPCNT_EN
  logic [15:0] drop_cnt;
  logic [31:0] drop_num;
  logic [31:0] drop_sum;

  always_comb begin
    drop_num = '0;
    for (int i = 0; i < N; i++) drop_num = drop_num + 32'(drop_vec[i]);
    drop_sum = 32'(drop_cnt) + drop_num;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) drop_cnt <= '0;
    else                    drop_cnt <= (drop_sum > 32'hFFFF) ? 16'hFFFF : drop_sum[15:0];
  end

  assign drop_cnt_o = drop_cnt;
`else
  assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_rv_iopmp_err_queue.sv
// Directed bench for rv_iopmp_err_queue (N=2, DEPTH=4) with an expected-record scoreboard.
module tb_rv_iopmp_err_queue;

`ifdef RV_IOPMP_ERRQ_DROPCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef logic [85:0] rec_t;

  logic              clk;
  logic              rst_ni;
  logic              clear_i;
  logic [1:0]        err_valid_i;
  logic [1:0][1:0]   err_ttype_i;
  logic [1:0][2:0]   err_etype_i;
  logic [1:0][15:0]  err_rrid_i;
  logic [1:0][63:0]  err_addr_i;
  logic              err_valid_o;
  logic              err_ready_i;
  logic [1:0]        err_ttype_o;
  logic [2:0]        err_etype_o;
  logic [15:0]       err_rrid_o;
  logic [63:0]       err_addr_o;
  logic [0:0]        err_src_o;
  logic [2:0]        level_o;
  logic              lost_o;
  logic [15:0]       drop_cnt_o;

  rec_t exp_q[$];
  int   total;
  int   bad;

  rv_iopmp_err_queue #(
    .NUMBER_IOPMP_INSTANCES(2),
    .DEPTH(4),
    .ADDR_WIDTH(64),
    .RRID_WIDTH(16)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .clear_i(clear_i),
    .err_valid_i(err_valid_i),
    .err_ttype_i(err_ttype_i),
    .err_etype_i(err_etype_i),
    .err_rrid_i(err_rrid_i),
    .err_addr_i(err_addr_i),
    .err_valid_o(err_valid_o),
    .err_ready_i(err_ready_i),
    .err_ttype_o(err_ttype_o),
    .err_etype_o(err_etype_o),
    .err_rrid_o(err_rrid_o),
    .err_addr_o(err_addr_o),
    .err_src_o(err_src_o),
    .level_o(level_o),
    .lost_o(lost_o),
    .drop_cnt_o(drop_cnt_o)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic rec_t mk(input logic src, input logic [1:0] tt, input logic [2:0] et,
                              input logic [15:0] rrid, input logic [63:0] addr);
    return {src, tt, et, rrid, addr};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: compare the head against the queue whenever a transfer happens at the next edge.
  task automatic tick();
    if (err_valid_o === 1'b1 && err_ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL sb_underflow observed=%0h expected=none",
               {err_src_o, err_ttype_o, err_etype_o, err_rrid_o, err_addr_o});
      end else begin
        chk("sb_head", {err_src_o, err_ttype_o, err_etype_o, err_rrid_o, err_addr_o},
            exp_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int inst, input logic [1:0] tt, input logic [2:0] et,
                       input logic [15:0] rrid, input logic [63:0] addr);
    err_valid_i[inst] = 1'b1;
    err_ttype_i[inst] = tt;
    err_etype_i[inst] = et;
    err_rrid_i[inst]  = rrid;
    err_addr_i[inst]  = addr;
  endtask

  task automatic idle();
    err_valid_i = '0;
  endtask

  initial begin
    logic [63:0] a;
    logic [15:0] r;
    logic [2:0]  e;
    logic [1:0]  t;
    total       = 0;
    bad         = 0;
    rst_ni      = 1'b0;
    clear_i     = 1'b0;
    err_valid_i = '0;
    err_ttype_i = '0;
    err_etype_i = '0;
    err_rrid_i  = '0;
    err_addr_i  = '0;
    err_ready_i = 1'b0;

    // reset state
    repeat (3) tick();
    chk("rst_valid", err_valid_o, 0);
    chk("rst_level", level_o, 0);
    chk("rst_lost", lost_o, 0);
    chk("rst_drop", drop_cnt_o, 0);
    chk("rst_fields", {err_src_o, err_ttype_o, err_etype_o, err_rrid_o, err_addr_o}, 0);
    rst_ni = 1'b1;
    tick();

    // single record, two-cycle latency, popped on arrival
    err_ready_i = 1'b1;
    drive(0, 2'd1, 3'd3, 16'h0012, 64'h8000_0000);
    exp_q.push_back(mk(1'b0, 2'd1, 3'd3, 16'h0012, 64'h8000_0000));
    tick();
    idle();
    chk("lat_t1_valid", err_valid_o, 0);
    tick();
    chk("lat_t2_valid", err_valid_o, 1);
    chk("lat_t2_addr", err_addr_o, 64'h8000_0000);
    chk("lat_t2_src", err_src_o, 0);
    chk("lat_t2_level", level_o, 1);
    tick();
    chk("lat_t3_level", level_o, 0);
    chk("lat_t3_valid", err_valid_o, 0);

    // clear resets the round-robin pointer; then both instances pulse together
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    err_ready_i = 1'b0;
    drive(0, 2'd2, 3'd1, 16'h000A, 64'h1000);
    drive(1, 2'd1, 3'd2, 16'h000B, 64'h2000);
    exp_q.push_back(mk(1'b0, 2'd2, 3'd1, 16'h000A, 64'h1000));
    exp_q.push_back(mk(1'b1, 2'd1, 3'd2, 16'h000B, 64'h2000));
    tick();
    idle();
    chk("rr_t1_level", level_o, 0);
    tick();
    chk("rr_t2_level", level_o, 1);
    chk("rr_first_src", err_src_o, 0);
    tick();
    chk("rr_t3_level", level_o, 2);
    chk("rr_lost", lost_o, 0);
    err_ready_i = 1'b1;
    tick();
    tick();
    err_ready_i = 1'b0;
    chk("rr_drained", level_o, 0);
    chk("rr_drop", drop_cnt_o, 0);

    // fill with ready low; the sixth pulse hits a full, ungranted hold (pointers wrap here)
    for (int k = 0; k < 6; k++) begin
      drive(0, 2'd2, 3'(k), 16'(16'h100 + k), 64'h4000_0000 + 64'(k * 16));
      if (k < 5) exp_q.push_back(mk(1'b0, 2'd2, 3'(k), 16'(16'h100 + k), 64'h4000_0000 + 64'(k * 16)));
      tick();
    end
    idle();
    chk("fill_level", level_o, 4);
    chk("fill_lost", lost_o, 1);
    chk("fill_drop", drop_cnt_o, CNT_EN ? 16'd1 : 16'd0);
    chk("fill_head", err_addr_o, 64'h4000_0000);
    tick();
    chk("stall_head", err_addr_o, 64'h4000_0000);
    chk("stall_level", level_o, 4);

    // pop from full: no grant that cycle, grant the next
    err_ready_i = 1'b1;
    tick();
    err_ready_i = 1'b0;
    chk("full_pop_level", level_o, 3);
    tick();
    chk("regrant_level", level_o, 4);
    err_ready_i = 1'b1;
    tick();
    err_ready_i = 1'b0;
    chk("pre_clear_level", level_o, 3);
    chk("pre_clear_lost", lost_o, 1);

    // clear while occupied; a pulse in the clear cycle is discarded
    drive(1, 2'd1, 3'd7, 16'hBEEF, 64'hDEAD);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    idle();
    exp_q.delete();
    chk("clr_valid", err_valid_o, 0);
    chk("clr_level", level_o, 0);
    chk("clr_lost", lost_o, 0);
    chk("clr_drop", drop_cnt_o, 0);
    tick();
    tick();
    chk("clr_pulse_gone", level_o, 0);
    chk("clr_pulse_nolost", lost_o, 0);

    // streaming random records with ready high: push and pop together keep level at 1
    err_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      a = {32'($urandom), 32'($urandom)};
      r = 16'($urandom_range(0, 65535));
      e = 3'($urandom_range(0, 7));
      t = 2'($urandom_range(1, 2));
      drive(1, t, e, r, a);
      exp_q.push_back(mk(1'b1, t, e, r, a));
      tick();
      if (k == 4) chk("stream_level", level_o, 1);
    end
    idle();
    repeat (3) tick();
    chk("stream_drained", level_o, 0);
    chk("stream_sb_empty", exp_q.size(), 0);
    chk("stream_lost", lost_o, 0);
    err_ready_i = 1'b0;

    // saturation: both instances pulse every cycle against a full FIFO
    for (int k = 0; k < 32800; k++) begin
      drive(0, 2'd1, 3'd0, 16'h1, 64'h10);
      drive(1, 2'd2, 3'd0, 16'h2, 64'h20);
      tick();
    end
    idle();
    chk("sat_drop", drop_cnt_o, CNT_EN ? 16'hFFFF : 16'h0000);
    chk("sat_lost", lost_o, 1);
    chk("sat_level", level_o, 4);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("sat_clr_drop", drop_cnt_o, 0);
    chk("sat_clr_level", level_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
